// File: rtl/para_to_serial_shifter_pkg.sv
// Shared types and elaboration helpers for the parallel-to-serial shifter.
package p2s_pkg;

   typedef enum logic {P2S_IDLE, P2S_SHIFT} p2s_state_t;

   function automatic int p2s_beats(input int data_w, input int lanes);
      return data_w / lanes;
   endfunction

   // Legal geometry: at least one lane, and the word splits into whole beats.
   function automatic bit p2s_cfg_ok(input int data_w, input int lanes);
      return (lanes >= 1) && (data_w >= lanes) && ((data_w % lanes) == 0);
   endfunction

endpackage

// File: rtl/para_to_serial_shifter.sv
// Parallel-to-serial converter: one word in via valid/ready, LANES bits out per beat,
// with a one-word holding register so consecutive words stream without an idle beat.
//
// state     | meaning
// P2S_IDLE  | shifter empty, oVALID low
// P2S_SHIFT | shifter holds a word, oVALID high
module para_to_serial_shifter
   import p2s_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int LANES     = 1,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iSTART,
   input  logic [DATA_W-1:0] iDATA,
   output logic              oREADY,
   output logic [LANES-1:0]  oSERIAL,
   output logic              oVALID,
   input  logic              iREADY,
   output logic              oLAST,
   output logic              oFINISHED,
   output logic              oBUSY,
   input  logic              iABORT
);

   localparam int BEATS = p2s_beats(DATA_W, LANES);
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

   generate
      if (!p2s_cfg_ok(DATA_W, LANES)) begin : g_cfg_err
         $error("para_to_serial_shifter: DATA_W must be a non-zero multiple of LANES");
      end
   endgenerate

   p2s_state_t        r_state;
   p2s_state_t        w_state_nxt;
   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] w_shifted;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_hold;
   logic              r_hold_valid;
   logic              r_finished;

   logic w_beat_take;
   logic w_last_beat;
   logic w_last_take;
   logic w_shift_free;
   logic w_accept;
   logic w_load_direct;
   logic w_load_hold;
   logic w_take_hold;

   assign w_beat_take   = (r_state == P2S_SHIFT) && iREADY;
   assign w_last_beat   = (r_state == P2S_SHIFT) && (r_cnt == LAST_CNT);
   assign w_last_take   = w_beat_take && w_last_beat;
   assign w_shift_free  = (r_state == P2S_IDLE) || w_last_take;
   assign w_accept      = iSTART && !r_hold_valid;
   assign w_load_direct = w_accept && w_shift_free;
   assign w_load_hold   = w_accept && !w_shift_free;
   assign w_take_hold   = r_hold_valid && w_shift_free;

   // Zero-fill keeps oSERIAL at 0 once a word has fully drained.
   generate
      if (BEATS == 1) begin : g_shift_one
         assign w_shifted = '0;
      end else if (MSB_FIRST) begin : g_shift_msb
         assign w_shifted = {r_shift[DATA_W-LANES-1:0], {LANES{1'b0}}};
      end else begin : g_shift_lsb
         assign w_shifted = {{LANES{1'b0}}, r_shift[DATA_W-1:LANES]};
      end
   endgenerate

   always_comb begin
      w_state_nxt = r_state;
      if (w_take_hold || w_load_direct) begin
         w_state_nxt = P2S_SHIFT;
      end else if (w_last_take) begin
         w_state_nxt = P2S_IDLE;
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST || iABORT) begin
         r_state <= P2S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST || iABORT) begin
         r_hold       <= '0;
         r_hold_valid <= 1'b0;
      end else if (w_load_hold) begin
         r_hold       <= iDATA;
         r_hold_valid <= 1'b1;
      end else if (w_take_hold) begin
         r_hold_valid <= 1'b0;
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST || iABORT) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (w_take_hold) begin
         r_shift <= r_hold;
         r_cnt   <= '0;
      end else if (w_load_direct) begin
         r_shift <= iDATA;
         r_cnt   <= '0;
      end else if (w_last_take) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (w_beat_take) begin
         r_shift <= w_shifted;
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST || iABORT) begin
         r_finished <= 1'b0;
      end else begin
         r_finished <= w_last_take;
      end
   end

   generate
      if (MSB_FIRST) begin : g_out_msb
         assign oSERIAL = r_shift[DATA_W-1 -: LANES];
      end else begin : g_out_lsb
         assign oSERIAL = r_shift[LANES-1:0];
      end
   endgenerate

   assign oVALID    = (r_state == P2S_SHIFT);
   assign oLAST     = w_last_beat;
   assign oREADY    = !r_hold_valid;
   assign oBUSY     = (r_state == P2S_SHIFT) || r_hold_valid;
   assign oFINISHED = r_finished;

endmodule

// File: tb/tb_para_to_serial_shifter.sv
// Directed bench for para_to_serial_shifter: an 8x1 MSB-first instance and a 16x4 LSB-first instance.
module tb_para_to_serial_shifter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       s8_start, s8_iready, s8_abort;
   logic [7:0] s8_data;
   logic       s8_rdy_o, s8_valid, s8_last, s8_fin, s8_busy;
   logic [0:0] s8_ser;

   logic        s16_start, s16_iready, s16_abort;
   logic [15:0] s16_data;
   logic        s16_rdy_o, s16_valid, s16_last, s16_fin, s16_busy;
   logic [3:0]  s16_ser;

   int n_checks = 0;
   int n_errors = 0;

   para_to_serial_shifter #(.DATA_W(8), .LANES(1), .MSB_FIRST(1'b1)) dut8 (
      .iCLK(clk), .iRST(rst), .iSTART(s8_start), .iDATA(s8_data), .oREADY(s8_rdy_o),
      .oSERIAL(s8_ser), .oVALID(s8_valid), .iREADY(s8_iready), .oLAST(s8_last),
      .oFINISHED(s8_fin), .oBUSY(s8_busy), .iABORT(s8_abort)
   );

   para_to_serial_shifter #(.DATA_W(16), .LANES(4), .MSB_FIRST(1'b0)) dut16 (
      .iCLK(clk), .iRST(rst), .iSTART(s16_start), .iDATA(s16_data), .oREADY(s16_rdy_o),
      .oSERIAL(s16_ser), .oVALID(s16_valid), .iREADY(s16_iready), .oLAST(s16_last),
      .oFINISHED(s16_fin), .oBUSY(s16_busy), .iABORT(s16_abort)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_word8(input logic [7:0] w);
      s8_data   = w;
      s8_start  = 1'b1;
      s8_iready = 1'b1;
      tick();
      s8_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("w8_valid", s8_valid, 1);
         check("w8_bit", s8_ser, w[7-i]);
         check("w8_last", s8_last, (i == 7));
         check("w8_fin_early", s8_fin, 0);
         tick();
      end
      check("w8_fin", s8_fin, 1);
      check("w8_idle_valid", s8_valid, 0);
      check("w8_idle_busy", s8_busy, 0);
      tick();
      check("w8_fin_pulse", s8_fin, 0);
   endtask

   initial begin
      logic [7:0]  w3 [3];
      logic [31:0] seq16;
      logic [23:0] bits;
      int nvalid, nfin, beat, idx;
      logic acc;

      rst = 1'b1;
      s8_start = 0; s8_iready = 1; s8_abort = 0; s8_data = '0;
      s16_start = 0; s16_iready = 1; s16_abort = 0; s16_data = '0;
      tick(); tick();
      rst = 1'b0;
      check("rst_valid", s8_valid, 0);
      check("rst_ready", s8_rdy_o, 1);
      check("rst_busy", s8_busy, 0);
      check("rst_last", s8_last, 0);
      check("rst_fin", s8_fin, 0);
      check("rst_serial", s8_ser, 0);
      tick();

      // 1: A5 MSB-first single-lane
      run_word8(8'hA5);

      // 3: backpressure on beat 3 for three cycles
      s8_data = 8'hA5; s8_start = 1; s8_iready = 1;
      tick();
      s8_start = 0;
      nvalid = 0; nfin = 0; beat = 0;
      for (int c = 0; c < 15; c++) begin
         s8_iready = !(c >= 2 && c < 5);
         if (s8_valid) begin
            nvalid++;
            check("bp_bit", s8_ser, s8_data[7-beat]);
            if (s8_iready) beat++;
         end
         if (s8_fin) nfin++;
         tick();
      end
      s8_iready = 1;
      check("bp_valid_cycles", nvalid, 11);
      check("bp_fin_count", nfin, 1);
      check("bp_beats", beat, 8);

      // 2: 16x4 LSB-first, second word offered during beat 2
      seq16 = 32'h4321DCBA;
      s16_data = 16'h1234; s16_start = 1;
      tick();
      s16_start = 0;
      for (int c = 0; c < 8; c++) begin
         if (c == 1) begin
            s16_data  = 16'hABCD;
            s16_start = 1;
         end
         check("l4_valid", s16_valid, 1);
         check("l4_nibble", s16_ser, seq16[31-4*c -: 4]);
         check("l4_last", s16_last, (c == 3 || c == 7));
         check("l4_fin", s16_fin, (c == 4));
         tick();
         if (c == 1) s16_start = 0;
      end
      check("l4_fin_end", s16_fin, 1);
      check("l4_idle", s16_valid, 0);

      // 4: three words back-to-back through the holding register
      w3[0] = 8'h3C; w3[1] = 8'h81; w3[2] = 8'hF0;
      idx = 0; bits = '0; nvalid = 0; nfin = 0;
      s8_start = 1; s8_data = w3[0];
      for (int c = 0; c < 30; c++) begin
         acc = s8_start && s8_rdy_o;
         tick();
         if (acc) begin
            idx++;
            if (idx == 2) check("hf_ready_low", s8_rdy_o, 0);
         end
         s8_start = (idx < 3);
         s8_data  = (idx < 3) ? w3[idx] : 8'h00;
         if (s8_valid) begin
            bits = {bits[22:0], s8_ser};
            nvalid++;
         end
         if (s8_fin) nfin++;
      end
      check("hf_accepted", idx, 3);
      check("hf_stream", bits, 24'h3C81F0);
      check("hf_valid_cycles", nvalid, 24);
      check("hf_fin_count", nfin, 3);

      // 5: abort at beat 4 with a word waiting in hold
      s8_data = 8'hA5; s8_start = 1;
      tick();
      s8_data = 8'h5A;
      tick();
      s8_start = 0;
      check("ab_hold_full", s8_rdy_o, 0);
      tick(); tick();
      s8_abort = 1;
      tick();
      s8_abort = 0;
      check("ab_valid", s8_valid, 0);
      check("ab_busy", s8_busy, 0);
      check("ab_ready", s8_rdy_o, 1);
      check("ab_fin", s8_fin, 0);
      check("ab_serial", s8_ser, 0);
      nvalid = 0; nfin = 0;
      for (int c = 0; c < 10; c++) begin
         if (s8_valid) nvalid++;
         if (s8_fin) nfin++;
         tick();
      end
      check("ab_quiet_valid", nvalid, 0);
      check("ab_quiet_fin", nfin, 0);

      // 6: reset at beat 5, then a fresh word
      s8_data = 8'hFF; s8_start = 1;
      tick();
      s8_start = 0;
      tick(); tick(); tick(); tick();
      rst = 1;
      tick();
      rst = 0;
      check("rs_valid", s8_valid, 0);
      check("rs_ready", s8_rdy_o, 1);
      check("rs_busy", s8_busy, 0);
      check("rs_last", s8_last, 0);
      check("rs_fin", s8_fin, 0);
      check("rs_serial", s8_ser, 0);
      tick();
      check("rs_no_fin", s8_fin, 0);
      run_word8(8'h96);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
